// File: rtl/wind_step_monitor_pkg.sv
// Shared widths, FSM encodings and the event record layout for the wind step monitor.
// Signed-zero-aware equality lives here so every consumer compares wind words the same way.
package wind_step_monitor_pkg;

   localparam int SINGLE     = 32;
   localparam int WIDTH_TIME = 32;
   localparam int WIND_EV_W  = WIDTH_TIME + 2*SINGLE;

   localparam logic [1:0] ST_INIT    = 2'd0;
   localparam logic [1:0] ST_TRACK   = 2'd1;
   localparam logic [1:0] ST_QUALIFY = 2'd2;

   typedef struct packed {
      logic [WIDTH_TIME-1:0] evTime;
      logic [SINGLE-1:0]     evOld;
      logic [SINGLE-1:0]     evNew;
   } windEvent_t;

   // +0.0 and -0.0 differ only in the sign bit and must compare equal
   function automatic logic windEq(input logic [SINGLE-1:0] a, input logic [SINGLE-1:0] b);
      return (a == b) || ((a[SINGLE-2:0] == '0) && (b[SINGLE-2:0] == '0));
   endfunction

endpackage

// File: rtl/wind_step_monitor_if.sv
// Event hand-off bus from the step monitor to the downstream logger.
interface wind_step_monitor_if;
   import wind_step_monitor_pkg::*;

   logic                  ev_valid;
   logic                  ev_ready;
   logic [WIDTH_TIME-1:0] ev_time;
   logic [SINGLE-1:0]     ev_old;
   logic [SINGLE-1:0]     ev_new;

   modport master (output ev_valid, output ev_time, output ev_old, output ev_new, input ev_ready);
   modport slave  (input ev_valid, input ev_time, input ev_old, input ev_new, output ev_ready);
endinterface

// File: rtl/wind_event_fifo.sv
// Synchronous first-word-fall-through FIFO; occupancy counter gives full/empty.
// Storage is cleared on reset so the head word reads as zero until the first push.
module wind_event_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   assign empty  = (count_q == '0);
   assign full   = (count_q == (AW+1)'(DEPTH));
   assign doPop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands
   assign doPush = push && (!full || doPop);
   assign dout   = mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= din;
            wrPtr_q        <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/wind_step_monitor.sv
// Qualifies wind-speed step changes over STABLE_CYC identical samples and queues
// timestamped {time, old, new} records for a downstream logger.
module wind_step_monitor
   import wind_step_monitor_pkg::*;
#(
   parameter int STABLE_CYC = 4,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH_TIME-1:0]   sim_time,
   input  logic [SINGLE-1:0]       VWind,
   wind_step_monitor_if.master     ev,
   output logic [SINGLE-1:0]       cur_wind,
   output logic                    overflow,
   output logic [15:0]             ev_count
);

   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);

   logic [1:0]        state_q,    state_d;
   logic [SINGLE-1:0] refWind_q,  refWind_d;
   logic [SINGLE-1:0] candWind_q, candWind_d;
   logic [7:0]        stableCnt_q, stableCnt_d;
   logic [15:0]       evCount_q,  evCount_d;
   logic              overflow_q, overflow_d;

   logic              accept;
   logic [SINGLE-1:0] acceptNew;
   logic              fifoEmpty;
   logic              fifoFull;
   windEvent_t        fifoDin;
   windEvent_t        fifoDout;

   // Step qualification: a candidate must repeat until the count reaches STABLE_CYC,
   // and a return to the reference value cancels it as a glitch
   always_comb begin
      state_d     = state_q;
      refWind_d   = refWind_q;
      candWind_d  = candWind_q;
      stableCnt_d = stableCnt_q;
      accept      = 1'b0;
      acceptNew   = candWind_q;
      case (state_q)
         ST_INIT: begin
            refWind_d = VWind;
            state_d   = ST_TRACK;
         end
         ST_TRACK: begin
            if (!windEq(VWind, refWind_q)) begin
               if (STABLE_CYC == 1) begin
                  accept    = 1'b1;
                  acceptNew = VWind;
               end else begin
                  candWind_d  = VWind;
                  stableCnt_d = 8'd1;
                  state_d     = ST_QUALIFY;
               end
            end
         end
         ST_QUALIFY: begin
            if (windEq(VWind, candWind_q)) begin
               if (stableCnt_q + 8'd1 == STABLE_LIM) begin
                  accept  = 1'b1;
                  state_d = ST_TRACK;
               end else begin
                  stableCnt_d = stableCnt_q + 8'd1;
               end
            end else if (windEq(VWind, refWind_q)) begin
               state_d = ST_TRACK;
            end else begin
               candWind_d  = VWind;
               stableCnt_d = 8'd1;
            end
         end
         default: state_d = ST_INIT;
      endcase
      if (accept) begin
         refWind_d = acceptNew;
      end
   end

   // Dropped events still count; overflow only when no same-cycle pop makes room
   always_comb begin
      evCount_d  = evCount_q + {15'd0, accept};
      overflow_d = overflow_q | (accept & fifoFull & ~ev.ev_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         refWind_q   <= '0;
         candWind_q  <= '0;
         stableCnt_q <= '0;
         evCount_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         refWind_q   <= refWind_d;
         candWind_q  <= candWind_d;
         stableCnt_q <= stableCnt_d;
         evCount_q   <= evCount_d;
         overflow_q  <= overflow_d;
      end
   end

   assign fifoDin.evTime = sim_time;
   assign fifoDin.evOld  = refWind_q;
   assign fifoDin.evNew  = acceptNew;

   wind_event_fifo #(
      .WIDTH (WIND_EV_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   (fifoDin),
      .pop   (ev.ev_ready),
      .dout  (fifoDout),
      .empty (fifoEmpty),
      .full  (fifoFull)
   );

   assign ev.ev_valid = ~fifoEmpty;
   assign ev.ev_time  = fifoDout.evTime;
   assign ev.ev_old   = fifoDout.evOld;
   assign ev.ev_new   = fifoDout.evNew;
   assign cur_wind    = refWind_q;
   assign overflow    = overflow_q;
   assign ev_count    = evCount_q;

endmodule

// File: tb/tb_wind_step_monitor.sv
// Directed bench for wind_step_monitor with STABLE_CYC=4 and a 2-deep event FIFO.
module tb_wind_step_monitor;

   localparam logic [31:0] W9P7 = 32'h411B3333;
   localparam logic [31:0] W12  = 32'h41400000;
   localparam logic [31:0] W14  = 32'h41600000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] simTime;
   logic [31:0] vWind;
   logic [31:0] curWind;
   logic        overflow;
   logic [15:0] evCount;
   int          checks = 0;
   int          errors = 0;
   logic        sawValid;
   logic [31:0] t1, t2, t3, t4, t5, tq;

   wind_step_monitor_if evBus ();

   wind_step_monitor #(.STABLE_CYC(4), .DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .sim_time (simTime),
      .VWind    (vWind),
      .ev       (evBus),
      .cur_wind (curWind),
      .overflow (overflow),
      .ev_count (evCount)
   );

   always #5 clk = ~clk;

   // Each tick presents the current simTime/vWind to one edge, then advances time
   task automatic tick();
      @(posedge clk);
      #1;
      simTime = simTime + 1;
   endtask

   task automatic applyStimulus(input logic [31:0] wind, input int n);
      vWind = wind;
      repeat (n) tick();
   endtask

   // A held step is accepted on its 4th sampling edge, three edges after the first
   task automatic stepTo(input logic [31:0] wind, output logic [31:0] evTime);
      evTime = simTime + 32'd3;
      applyStimulus(wind, 6);
   endtask

   task automatic popOne();
      evBus.ev_ready = 1'b1;
      tick();
      evBus.ev_ready = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkHead(input string tag, input logic [31:0] t, input logic [31:0] o, input logic [31:0] n);
      checkOutput({tag, "_valid"}, 96'(evBus.ev_valid), 96'd1);
      checkOutput({tag, "_rec"}, {evBus.ev_time, evBus.ev_old, evBus.ev_new}, {t, o, n});
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_valid"}, 96'(evBus.ev_valid), 96'd0);
      checkOutput({tag, "_rec"}, {evBus.ev_time, evBus.ev_old, evBus.ev_new}, 96'd0);
      checkOutput({tag, "_cur"}, 96'(curWind), 96'd0);
      checkOutput({tag, "_ovf"}, 96'(overflow), 96'd0);
      checkOutput({tag, "_cnt"}, 96'(evCount), 96'd0);
   endtask

   initial begin
      rst            = 1'b1;
      simTime        = 32'd0;
      vWind          = 32'd0;
      evBus.ev_ready = 1'b0;
      tick();
      tick();
      checkResetState("reset");

      rst      = 1'b0;
      vWind    = W9P7;
      sawValid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (evBus.ev_valid) sawValid = 1'b1;
      end
      checkOutput("idle_valid", 96'(sawValid), 96'd0);
      checkOutput("idle_cur", 96'(curWind), 96'(W9P7));
      checkOutput("idle_cnt", 96'(evCount), 96'd0);

      simTime = 32'd400001;
      applyStimulus(W12, 3);
      checkOutput("step_early", 96'(evBus.ev_valid), 96'd0);
      checkOutput("step_early_cur", 96'(curWind), 96'(W9P7));
      tick();
      checkHead("step", 32'd400004, W9P7, W12);
      checkOutput("step_cur", 96'(curWind), 96'(W12));
      checkOutput("step_cnt", 96'(evCount), 96'd1);
      popOne();
      checkOutput("step_popped", 96'(evBus.ev_valid), 96'd0);

      applyStimulus(W14, 2);
      applyStimulus(W12, 5);
      checkOutput("glitch_valid", 96'(evBus.ev_valid), 96'd0);
      checkOutput("glitch_cur", 96'(curWind), 96'(W12));
      checkOutput("glitch_cnt", 96'(evCount), 96'd1);

      // Candidate replaced mid-qualification restarts the stability count
      applyStimulus(W14, 2);
      t1 = simTime + 32'd3;
      applyStimulus(W9P7, 4);
      checkHead("retarget", t1, W12, W9P7);
      checkOutput("retarget_cnt", 96'(evCount), 96'd2);
      popOne();

      stepTo(W14, t1);
      stepTo(W12, t2);
      checkOutput("full_ovf", 96'(overflow), 96'd0);
      t3 = simTime + 32'd3;
      applyStimulus(W9P7, 3);
      evBus.ev_ready = 1'b1;
      tick();
      evBus.ev_ready = 1'b0;
      applyStimulus(W9P7, 2);
      checkOutput("pushpop_ovf", 96'(overflow), 96'd0);
      checkOutput("pushpop_cnt", 96'(evCount), 96'd5);
      checkHead("pushpop_h0", t2, W14, W12);
      popOne();
      checkHead("pushpop_h1", t3, W12, W9P7);
      popOne();
      checkOutput("pushpop_empty", 96'(evBus.ev_valid), 96'd0);

      stepTo(W14, t4);
      stepTo(W12, t5);
      stepTo(W9P7, tq);
      checkOutput("drop_ovf", 96'(overflow), 96'd1);
      checkOutput("drop_cnt", 96'(evCount), 96'd8);
      checkOutput("drop_cur", 96'(curWind), 96'(W9P7));
      checkHead("drop_h0", t4, W9P7, W14);
      popOne();
      checkHead("drop_h1", t5, W14, W12);
      popOne();
      checkOutput("drop_empty", 96'(evBus.ev_valid), 96'd0);
      checkOutput("drop_sticky", 96'(overflow), 96'd1);

      stepTo(W14, t1);
      stepTo(W12, t2);
      applyStimulus(W9P7, 2);
      rst = 1'b1;
      tick();
      checkResetState("midrst");

      rst = 1'b0;
      applyStimulus(W12, 4);
      checkOutput("rebase_cur", 96'(curWind), 96'(W12));
      checkOutput("rebase_valid", 96'(evBus.ev_valid), 96'd0);
      checkOutput("rebase_cnt", 96'(evCount), 96'd0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(32'h00000000, 3);
      applyStimulus(32'h80000000, 8);
      checkOutput("negzero_valid", 96'(evBus.ev_valid), 96'd0);
      checkOutput("negzero_cnt", 96'(evCount), 96'd0);
      checkOutput("negzero_cur", 96'(curWind), 96'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
